// File: rtl/triangle_raster_walker_if.sv
// Start/vertex request and covered-pixel stream for triangle_raster_walker.
// slave = rasterizer side, master = the block feeding triangles and taking pixels.
interface triangle_raster_walker_if #(
    parameter int COORD_W = 10,
    localparam int EW = 2*COORD_W+3
);
    logic                      i_start;
    logic [COORD_W-1:0]        i_v1x, i_v1y, i_v2x, i_v2y, i_v3x, i_v3y;
    logic                      o_idle;
    logic                      o_valid;
    logic                      i_ready;
    logic [COORD_W-1:0]        o_x, o_y;
    logic signed [EW-1:0]      o_w1, o_w2, o_w3, o_area;
    logic                      o_done;

    modport slave (
        input  i_start, i_v1x, i_v1y, i_v2x, i_v2y, i_v3x, i_v3y, i_ready,
        output o_idle, o_valid, o_x, o_y, o_w1, o_w2, o_w3, o_area, o_done
    );
    modport master (
        output i_start, i_v1x, i_v1y, i_v2x, i_v2y, i_v3x, i_v3y, i_ready,
        input  o_idle, o_valid, o_x, o_y, o_w1, o_w2, o_w3, o_area, o_done
    );
endinterface

// File: rtl/triangle_raster_walker.sv
// Bounding-box triangle walker: one pixel per cycle, incremental edge functions,
// emits covered pixels with unnormalised barycentric weights and the area.
module triangle_raster_walker #(
    parameter int COORD_W       = 10,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int BOTH_WINDINGS = 1,
    localparam int EW = 2*COORD_W+3
) (
    input logic i_clk,
    input logic i_reset,
    triangle_raster_walker_if.slave bus
);
    typedef logic signed [EW-1:0]        e_t;
    typedef logic signed [COORD_W:0]     d_t;
    typedef logic signed [2*COORD_W+1:0] p_t;
    typedef logic [COORD_W-1:0]          c_t;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_INIT  = 3'd2;
    localparam logic [2:0] S_WALK  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam c_t XLIM = c_t'(SCREEN_W-1);
    localparam c_t YLIM = c_t'(SCREEN_H-1);

    function automatic e_t edge_fn(input c_t ax, input c_t ay, input c_t bx,
                                   input c_t by, input c_t px, input c_t py);
        d_t dx, dy, qx, qy;
        dx = $signed({1'b0, bx}) - $signed({1'b0, ax});
        dy = $signed({1'b0, by}) - $signed({1'b0, ay});
        qx = $signed({1'b0, px}) - $signed({1'b0, ax});
        qy = $signed({1'b0, py}) - $signed({1'b0, ay});
        return e_t'(p_t'(dx) * p_t'(qy)) - e_t'(p_t'(dy) * p_t'(qx));
    endfunction

    function automatic e_t sx(input d_t d);
        return e_t'(d);
    endfunction

    function automatic int nxt(input int k);
        return (k == 2) ? 0 : k + 1;
    endfunction

    function automatic c_t min3(input c_t a, input c_t b, input c_t c);
        c_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic c_t max3(input c_t a, input c_t b, input c_t c);
        c_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    logic [2:0] r_state;
    c_t         r_vx [3];
    c_t         r_vy [3];
    d_t         r_dx [3];
    d_t         r_dy [3];
    e_t         r_e  [3];
    e_t         r_row[3];
    c_t         r_xmin, r_xmax, r_ymin, r_ymax, r_px, r_py;
    logic       r_neg;
    e_t         r_area_abs;

    logic       r_valid;
    c_t         r_x, r_y;
    e_t         r_w [3];
    e_t         r_area;

    e_t   w_area;
    c_t   w_xmin, w_xmax, w_ymin, w_ymax, w_xmax_raw, w_ymax_raw;
    logic w_bb_empty, w_neg, w_skip;
    e_t   w_w [3];
    logic w_cov, w_adv;

    always_comb begin
        w_area     = edge_fn(r_vx[0], r_vy[0], r_vx[1], r_vy[1], r_vx[2], r_vy[2]);
        w_neg      = w_area[EW-1];
        w_xmin     = min3(r_vx[0], r_vx[1], r_vx[2]);
        w_ymin     = min3(r_vy[0], r_vy[1], r_vy[2]);
        w_xmax_raw = max3(r_vx[0], r_vx[1], r_vx[2]);
        w_ymax_raw = max3(r_vy[0], r_vy[1], r_vy[2]);
        // Vertices are unsigned, so only the upper edge of the box needs clamping.
        w_xmax     = (w_xmax_raw > XLIM) ? XLIM : w_xmax_raw;
        w_ymax     = (w_ymax_raw > YLIM) ? YLIM : w_ymax_raw;
        w_bb_empty = (w_xmin > w_xmax) || (w_ymin > w_ymax);
        w_skip     = (w_area == '0) || (w_neg && (BOTH_WINDINGS == 0)) || w_bb_empty;
    end

    always_comb begin
        w_cov = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w_w[k] = r_neg ? -r_e[k] : r_e[k];
            if (w_w[k][EW-1]) w_cov = 1'b0;
        end
        w_adv = !r_valid || bus.i_ready;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_valid    <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_area     <= '0;
            r_xmin     <= '0;
            r_xmax     <= '0;
            r_ymin     <= '0;
            r_ymax     <= '0;
            r_px       <= '0;
            r_py       <= '0;
            r_neg      <= 1'b0;
            r_area_abs <= '0;
            for (int k = 0; k < 3; k++) begin
                r_vx[k]  <= '0;
                r_vy[k]  <= '0;
                r_dx[k]  <= '0;
                r_dy[k]  <= '0;
                r_e[k]   <= '0;
                r_row[k] <= '0;
                r_w[k]   <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: if (bus.i_start) begin
                    r_vx[0] <= bus.i_v1x;  r_vy[0] <= bus.i_v1y;
                    r_vx[1] <= bus.i_v2x;  r_vy[1] <= bus.i_v2y;
                    r_vx[2] <= bus.i_v3x;  r_vy[2] <= bus.i_v3y;
                    r_state <= S_SETUP;
                end
                S_SETUP: begin
                    for (int k = 0; k < 3; k++) begin
                        r_dx[k] <= $signed({1'b0, r_vx[nxt(k)]}) - $signed({1'b0, r_vx[k]});
                        r_dy[k] <= $signed({1'b0, r_vy[nxt(k)]}) - $signed({1'b0, r_vy[k]});
                    end
                    r_xmin     <= w_xmin;
                    r_xmax     <= w_xmax;
                    r_ymin     <= w_ymin;
                    r_ymax     <= w_ymax;
                    r_neg      <= w_neg;
                    r_area_abs <= w_neg ? -w_area : w_area;
                    r_state    <= w_skip ? S_DONE : S_INIT;
                end
                S_INIT: begin
                    for (int k = 0; k < 3; k++) begin
                        r_e[k]   <= edge_fn(r_vx[k], r_vy[k], r_vx[nxt(k)], r_vy[nxt(k)], r_xmin, r_ymin);
                        r_row[k] <= edge_fn(r_vx[k], r_vy[k], r_vx[nxt(k)], r_vy[nxt(k)], r_xmin, r_ymin);
                    end
                    r_px    <= r_xmin;
                    r_py    <= r_ymin;
                    r_state <= S_WALK;
                end
                S_WALK: if (w_adv) begin
                    r_valid <= w_cov;
                    if (w_cov) begin
                        r_x    <= r_px;
                        r_y    <= r_py;
                        r_area <= r_area_abs;
                        for (int k = 0; k < 3; k++) r_w[k] <= w_w[k];
                    end
                    if (r_px == r_xmax) begin
                        if (r_py == r_ymax) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_px <= r_xmin;
                            r_py <= r_py + c_t'(1);
                            for (int k = 0; k < 3; k++) begin
                                r_row[k] <= r_row[k] + sx(r_dx[k]);
                                r_e[k]   <= r_row[k] + sx(r_dx[k]);
                            end
                        end
                    end else begin
                        r_px <= r_px + c_t'(1);
                        for (int k = 0; k < 3; k++) r_e[k] <= r_e[k] - sx(r_dy[k]);
                    end
                end
                S_DRAIN: if (!r_valid || bus.i_ready) begin
                    r_valid <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_idle  = (r_state == S_IDLE);
    assign bus.o_done  = (r_state == S_DONE);
    assign bus.o_valid = r_valid;
    assign bus.o_x     = r_x;
    assign bus.o_y     = r_y;
    assign bus.o_w1    = r_w[0];
    assign bus.o_w2    = r_w[1];
    assign bus.o_w3    = r_w[2];
    assign bus.o_area  = r_area;
endmodule

// File: doc/triangle_raster_walker.md
# triangle_raster_walker

Sequential, parametrised triangle rasterizer. It accepts one triangle of integer screen-space vertices, computes a clipped bounding box and edge-function coefficients, then walks the box in raster order. Each cycle it evaluates one pixel incrementally (E = Ax + By + C). Covered pixels are emitted on a valid/ready stream with unnormalised barycentric weights and triangle area; normalisation and colour interpolation happen in the downstream shading stage.

## Interface
Parameters:
- COORD_W, 10, unsigned vertex/pixel coordinate width
- SCREEN_W, 640, screen width in pixels; x clipped to [0, SCREEN_W-1]
- SCREEN_H, 480, screen height in pixels; y clipped to [0, SCREEN_H-1]
- BOTH_WINDINGS, 1, 1 = accept either winding; 0 = cull triangles with negative area
- Derived: EW = 2*COORD_W+3, signed edge-function width

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  start request; honoured only when o_idle=1
- i_v1x, i_v1y, i_v2x, i_v2y, i_v3x, i_v3y  in  COORD_W each  unsigned vertex coordinates, sampled on the accepted i_start cycle
- o_idle  out  1  block is in IDLE and able to accept i_start
- o_valid  out  1  output pixel valid
- i_ready  in  1  downstream accepts the pixel
- o_x, o_y  out  COORD_W each  pixel coordinate
- o_w1, o_w2, o_w3  out  EW each  signed weights for edges v1→v2, v2→v3, v3→v1; always ≥0 when valid
- o_area  out  EW  signed area; always >0 while a triangle is being walked
- o_done  out  1  one-cycle pulse when a triangle completes

## Operation
- Edge function: E_ab(p) = (bx−ax)(py−ay) − (by−ay)(px−ax).
- Difference terms are COORD_W+1 signed and products are 2*COORD_W+2 signed. All edge-function arithmetic is carried out in EW bits with no overflow.
- Area: area = E_12(v3).
- Inside test: pixel is covered iff w1≥0, w2≥0 and w3≥0, with ties included.
- Winding:
  - If area<0 and BOTH_WINDINGS=1, negate all three weights and the area.
  - If area<0 and BOTH_WINDINGS=0, the triangle emits nothing.
- Incremental stepping:
  - x+1: E −= (by−ay).
  - Next row: E = row-start E + (bx−ax).
  - No multipliers are used in WALK.
- Bounding box: min/max over the vertices, clamped to the screen. If min>max on either axis (fully off-screen), the triangle emits nothing.
- Walk order: y ascending, then x ascending within each row.
- States:
  - IDLE: o_idle=1. On i_start, capture the vertices and go to SETUP.
  - SETUP: compute bbox, coefficients and area. If area==0, culled, or bbox empty, go to DONE; else go to INIT.
  - INIT: evaluate E1..E3 at (xmin,ymin) and store the row-start values; go to WALK.
  - WALK: advance one pixel when the output register is free (!o_valid || i_ready).
    - Covered pixel: load o_x, o_y, o_w*, o_area and set o_valid.
    - Uncovered pixel: clear o_valid if it was just accepted.
    - After (xmax,ymax) is evaluated, go to DRAIN.
  - DRAIN: hold until !o_valid, or o_valid&&i_ready, then go to DONE.
  - DONE: o_done=1 for one cycle, then IDLE.
- i_start is ignored outside IDLE, and vertex inputs are don't-care outside the start cycle.
- Invariant: o_w1+o_w2+o_w3 == o_area for every emitted pixel.

## Timing
- Reset (asynchronous, any state including mid-walk):
  - State goes to IDLE.
  - o_idle=1.
  - o_valid=0, o_done=0.
  - o_x, o_y, o_w*, o_area = 0.
  - No pixel is emitted after reset deassertion until a new i_start.
- Start accepted in cycle 0: SETUP in cycle 1, INIT in cycle 2, first WALK evaluation in cycle 3. The earliest o_valid is cycle 4.
- Empty, degenerate or culled triangle: o_done in cycle 2 and o_idle=1 in cycle 3.
- Throughput is one bbox pixel per cycle while not stalled. Uncovered pixels cost one cycle each.
- While o_valid=1 and i_ready=0, all outputs hold stable and the walk stalls.
- o_done asserts the cycle after the final handshake. o_valid is never high in the same cycle as o_done.

## Test plan
- Basic triangle v=(0,0),(4,0),(0,4): exactly 15 pixels with x+y≤4, in raster order. Pixel (1,1) gives w1=4, w2=8, w3=4, area=16. Then one o_done.
- Reversed winding v=(0,0),(0,4),(4,0):
  - BOTH_WINDINGS=1: same 15 pixels, weights ≥0, area=16.
  - BOTH_WINDINGS=0: zero pixels, o_done in cycle 2.
- Degenerate v=(0,0),(2,2),(4,4): no o_valid, o_done in cycle 2. A fully off-screen triangle (x≥700 with SCREEN_W=640) gives the same result.
- Back-pressure on the basic triangle: i_ready=0 for 5 cycles at the first pixel and random thereafter → outputs stable while stalled; the same 15 pixels, none lost or duplicated; weight-sum invariant holds.
- Clipping v=(630,0),(700,0),(630,70) with SCREEN_W=640: only x in 630..639 emitted, all satisfying the inside test.
- Reset asserted mid-WALK: o_valid and o_done go to 0 immediately. A new i_start with the basic triangle then yields exactly 15 pixels. An i_start pulsed during WALK is ignored.
